cache_refill_fsm: RTL and testbench

Parametrised miss-handling controller for the write-back data cache: on a miss it streams the victim line out (if dirty) and the new line in, one word per memory handshake. It generalises the fixed three-state normal/write/fetch controller with a configurable line length and a valid/ready memory interface. It also adds optional critical-word-first refill ordering. It sits between the cache array/tag compare logic and the memory port arbiter.

---
 rtl/cache_pkg.sv | 12 +
 rtl/cache_refill_fsm_if.sv | 27 ++
 rtl/cache_beat_counter.sv | 24 ++
 rtl/cache_refill_fsm.sv | 111 +++++++++++
 tb/tb_cache_refill_fsm.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encodings and default line length for the cache refill controller
package cache_pkg;

    localparam int LINE_WORDS_DEFAULT = 16;

    typedef enum logic [1:0] {
        NORMAL = 2'b10,
        WRITE  = 2'b00,
        FETCH  = 2'b01
    } cache_state_t;

endpackage

// File: rtl/cache_refill_fsm_if.sv
// rtl/cache_refill_fsm_if.sv - word-per-beat valid/ready memory port between refill controller and arbiter
interface cache_refill_fsm_if
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
);
    localparam int OFFSET_W = $clog2(LINE_WORDS);

    logic                mem_valid;
    logic                mem_write;
    logic [OFFSET_W-1:0] mem_offset;
    logic                mem_ready;

    modport master (
        output mem_valid,
        output mem_write,
        output mem_offset,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_write,
        input  mem_offset,
        output mem_ready
    );
endinterface

// File: rtl/cache_beat_counter.sv
// rtl/cache_beat_counter.sv - per-phase beat counter with clear, increment-on-beat and last-beat flag
module cache_beat_counter #(
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    output logic [OFFSET_W-1:0] cnt,
    output logic                last
);
    // clear wins over inc so a phase change on the final beat restarts at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = &cnt;
endmodule

// File: rtl/cache_refill_fsm.sv
// rtl/cache_refill_fsm.sv - write-back cache miss controller: victim write-back then line refill
// Optional critical-word-first refill ordering: CACHE_CRITICAL_WORD_EN
module cache_refill_fsm
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int OFFSET_W   = $clog2(LINE_WORDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                req,
    input  logic [OFFSET_W-1:0] req_offset,
    input  logic                line_hit,
    input  logic                line_dirty,
    cache_refill_fsm_if.master  mem,
    output logic                line_fill,
`ifdef CACHE_CRITICAL_WORD_EN
    output logic                crit_ready,
`endif
    output logic                stall,
    output logic [1:0]          state
);
    cache_state_t        state_q, state_d;
    logic                cnt_clr;
    logic                beat;
    logic                miss;
    logic                cnt_last;
    logic [OFFSET_W-1:0] cnt;
    logic [OFFSET_W-1:0] start;

    cache_beat_counter #(.OFFSET_W(OFFSET_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clr),
        .inc   (beat),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    assign miss          = req && !line_hit;
    assign mem.mem_valid = en && (state_q != NORMAL);
    assign beat          = mem.mem_valid && mem.mem_ready;

`ifdef CACHE_CRITICAL_WORD_EN
    logic [OFFSET_W-1:0] base;

    always_ff @(posedge clk) begin
        if (reset) begin
            base <= '0;
        end else if (en && state_q == NORMAL && miss) begin
            base <= req_offset;
        end
    end

    assign start      = base;
    assign crit_ready = beat && (state_q == FETCH) && (cnt == '0);
`else
    logic unused_req_offset;

    assign unused_req_offset = ^req_offset;
    assign start             = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_clr        = 1'b0;
        line_fill      = 1'b0;
        mem.mem_write  = 1'b0;
        mem.mem_offset = '0;
        case (state_q)
            NORMAL: begin
                if (en && miss) begin
                    state_d = line_dirty ? WRITE : FETCH;
                    cnt_clr = 1'b1;
                end
            end
            WRITE: begin
                mem.mem_write  = 1'b1;
                mem.mem_offset = cnt;
                if (beat && cnt_last) begin
                    state_d = FETCH;
                    cnt_clr = 1'b1;
                end
            end
            FETCH: begin
                // offset wraps naturally at OFFSET_W bits, giving the wrapped critical-word order
                mem.mem_offset = start + cnt;
                if (beat && cnt_last) begin
                    line_fill = 1'b1;
                    state_d   = NORMAL;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    assign stall = (state_q != NORMAL) || miss;
    assign state = state_q;
endmodule

// File: tb/tb_cache_refill_fsm.sv
// tb/tb_cache_refill_fsm.sv - scoreboard bench for cache_refill_fsm
module tb_cache_refill_fsm;
    import cache_pkg::*;

`ifdef CACHE_CRITICAL_WORD_EN
    localparam int LW = 16;
`else
    localparam int LW = 4;
`endif
    localparam int OW = $clog2(LW);

    typedef struct {
        logic          wr;
        logic [OW-1:0] off;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          req;
    logic [OW-1:0] req_offset;
    logic          line_hit;
    logic          line_dirty;
    logic          line_fill;
    logic          stall;
    logic [1:0]    state;
`ifdef CACHE_CRITICAL_WORD_EN
    logic          crit_ready;
`endif

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t exp_q[$];

    cache_refill_fsm_if #(.LINE_WORDS(LW)) mem_if ();

    cache_refill_fsm #(.LINE_WORDS(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req        (req),
        .req_offset (req_offset),
        .line_hit   (line_hit),
        .line_dirty (line_dirty),
        .mem        (mem_if),
        .line_fill  (line_fill),
`ifdef CACHE_CRITICAL_WORD_EN
        .crit_ready (crit_ready),
`endif
        .stall      (stall),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode 0: mem_ready always 1; mode 1: ready pattern 1,0,0 repeating
    task automatic run_miss(input logic dirty, input logic [OW-1:0] off, input int mode, input bit drop_en);
        int            cyc        = 0;
        int            busy       = 0;
        int            fetch_done = 0;
        int            en_low     = 0;
        bit            done       = 0;
        logic [OW-1:0] start;
        logic          bt;
        beat_t         b;
`ifdef CACHE_CRITICAL_WORD_EN
        start = off;
`else
        start = '0;
`endif
        exp_q.delete();
        if (dirty) begin
            for (int i = 0; i < LW; i++) begin
                b.wr  = 1'b1;
                b.off = OW'(i);
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < LW; i++) begin
            b.wr  = 1'b0;
            b.off = start + OW'(i);
            exp_q.push_back(b);
        end

        req = 1'b1; line_hit = 1'b0; line_dirty = dirty; req_offset = off;
        en = 1'b1; mem_if.mem_ready = 1'b1;
        @(negedge clk);
        check_eq("miss_stall", stall, 1);
        check_eq("miss_state", state, NORMAL);
        check_eq("miss_valid", mem_if.mem_valid, 0);
        @(posedge clk); #1;
        req = 1'b0; line_dirty = ~dirty;

        while (!done && cyc < 400) begin
            mem_if.mem_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (drop_en && fetch_done == 2 && en_low < 3) begin
                en = 1'b0;
                en_low++;
            end else begin
                en = 1'b1;
            end
            @(negedge clk);
            if (state == NORMAL) begin
                done = 1;
                check_eq("idle_valid", mem_if.mem_valid, 0);
                check_eq("idle_stall", stall, 0);
            end else begin
                busy++;
                check_eq("busy_stall", stall, 1);
                if (!en) begin
                    check_eq("en_low_valid", mem_if.mem_valid, 0);
                    check_eq("en_low_state", state, FETCH);
                    check_eq("en_low_fill", line_fill, 0);
                end else if (exp_q.size() == 0) begin
                    check_eq("q_underflow", exp_q.size(), 1);
                end else begin
                    bt = mem_if.mem_ready;
                    check_eq("valid", mem_if.mem_valid, 1);
                    check_eq("state", state, exp_q[0].wr ? WRITE : FETCH);
                    check_eq("write", mem_if.mem_write, exp_q[0].wr);
                    check_eq("offset", mem_if.mem_offset, exp_q[0].off);
                    check_eq("line_fill", line_fill, bt && exp_q.size() == 1);
`ifdef CACHE_CRITICAL_WORD_EN
                    check_eq("crit_ready", crit_ready, bt && !exp_q[0].wr && fetch_done == 0);
`endif
                    if (bt) begin
                        if (!exp_q[0].wr) fetch_done++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("completed", done, 1);
        check_eq("q_drained", exp_q.size(), 0);
        if (mode == 0 && !drop_en)
            check_eq("busy_cycles", busy, dirty ? 2 * LW : LW);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; req = 1'b0; req_offset = '0;
        line_hit = 1'b0; line_dirty = 1'b0; mem_if.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_state", state, NORMAL);
        check_eq("rst_valid", mem_if.mem_valid, 0);
        check_eq("rst_write", mem_if.mem_write, 0);
        check_eq("rst_fill", line_fill, 0);
        check_eq("rst_stall", stall, 0);

        // hit: no transition and no stall
        @(posedge clk); #1;
        req = 1'b1; line_hit = 1'b1; line_dirty = 1'b1;
        @(negedge clk);
        check_eq("hit_stall", stall, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("hit_state", state, NORMAL);

        // miss with en low must not start a refill
        @(posedge clk); #1;
        en = 1'b0; line_hit = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("en_low_miss_state", state, NORMAL);
        check_eq("en_low_miss_stall", stall, 1);
        @(posedge clk); #1;
        req = 1'b0; en = 1'b1;

        run_miss(1'b0, OW'(LW - 3), 0, 0);
        run_miss(1'b1, OW'(1), 0, 0);
        run_miss(1'b1, OW'(LW - 1), 1, 0);
        run_miss(1'b0, OW'(LW - 3), 0, 1);

        // reset during write-back at cnt=1
        req = 1'b1; line_hit = 1'b0; line_dirty = 1'b1; mem_if.mem_ready = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        mem_if.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_state", state, WRITE);
        check_eq("pre_rst_offset", mem_if.mem_offset, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_state", state, NORMAL);
        check_eq("mid_rst_valid", mem_if.mem_valid, 0);
        check_eq("mid_rst_write", mem_if.mem_write, 0);
        check_eq("mid_rst_fill", line_fill, 0);
        @(posedge clk); #1;
        run_miss(1'b1, OW'(2), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
